// File: rtl/calendar_pkg.sv
// Shared calendar definitions: month and day-of-week encodings, the
// date-unit FSM states and the days-in-month lookup.
package calendar_pkg;

    localparam logic [3:0] MON_JAN = 4'd1;
    localparam logic [3:0] MON_FEB = 4'd2;
    localparam logic [3:0] MON_APR = 4'd4;
    localparam logic [3:0] MON_JUN = 4'd6;
    localparam logic [3:0] MON_SEP = 4'd9;
    localparam logic [3:0] MON_NOV = 4'd11;
    localparam logic [3:0] MON_DEC = 4'd12;

    // 0 = Sunday ... 6 = Saturday
    localparam logic [2:0] DOW_SUN = 3'd0;
    localparam logic [2:0] DOW_SAT = 3'd6;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        CALC400 = 2'd1,
        CALC100 = 2'd2
    } cal_state_e;

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic       leap);
        logic [4:0] d;
        d = 5'd31;
        case (month)
            MON_FEB: d = leap ? 5'd29 : 5'd28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: d = 5'd30;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cal_residue_calc.sv
// Maintains year mod 400 and year mod 100. Rebuilt by repeated subtraction
// after a start, otherwise stepped by one on each year rollover.
module cal_residue_calc
    import calendar_pkg::*;
#(
    parameter int RES_W    = 12,
    parameter int RST_R400 = 0,
    parameter int RST_R100 = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RES_W-1:0] start_val,
    input  logic             inc,
    output logic [RES_W-1:0] r400,
    output logic [8:0]       r100,
    output logic             busy,
    output logic             done
);

    cal_state_e state;

    assign busy = (state != RUN);
    // Final cycle of the recalculation: both residues are settled here.
    assign done = (state == CALC100) && (r100 < 9'd100);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            r400  <= RES_W'(RST_R400);
            r100  <= 9'(RST_R100);
        end else begin
            case (state)
                RUN: begin
                    if (start) begin
                        r400  <= start_val;
                        state <= CALC400;
                    end else if (inc) begin
                        r400 <= (r400 == RES_W'(399)) ? '0 : r400 + 1'b1;
                        r100 <= (r100 == 9'd99) ? 9'd0 : r100 + 9'd1;
                    end
                end
                CALC400: begin
                    if (r400 >= RES_W'(400)) begin
                        r400 <= r400 - RES_W'(400);
                    end else begin
                        r100  <= r400[8:0];
                        state <= CALC100;
                    end
                end
                CALC100: begin
                    if (r100 >= 9'd100) begin
                        r100 <= r100 - 9'd100;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/calendar_date_unit.sv
// Date keeper: advances day/month/year/day-of-week on the day strobe,
// applies Gregorian leap rules and accepts validated date loads.
module calendar_date_unit
    import calendar_pkg::*;
#(
    parameter int YEAR_W   = 12,
    parameter int YEAR_MIN = 0,
    parameter int YEAR_MAX = 4095,
    parameter int RST_YEAR = 2000,
    parameter int RST_DOW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              day_tick,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [2:0]        load_dow,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        dow,
    output logic              leap,
    output logic [4:0]        dim,
    output logic              busy,
    output logic              month_end,
    output logic              year_end,
    output logic              year_wrap,
    output logic              load_err,
    output logic              day_clamped,
    output logic              tick_lost
);

    localparam int RES_W    = (YEAR_W > 9) ? YEAR_W : 9;
    localparam int RST_R400 = RST_YEAR % 400;
    localparam int RST_R100 = RST_YEAR % 100;
    localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

    logic [RES_W-1:0] r400;
    logic [8:0]       r100;
    logic             calc_done;
    logic             tick_pend;
    logic             accept, load_ok, take_load, adv;
    logic             last_day, year_roll, wrap, clamp_now;
    logic             res_start, res_inc;
    logic [RES_W-1:0] res_val;

    // Unsigned range test done by offset so it stays valid when YEAR_MIN is 0.
    function automatic logic year_in_range(input logic [YEAR_W-1:0] y);
        logic [YEAR_W:0] off;
        off = {1'b0, y} - (YEAR_W+1)'(YEAR_MIN);
        return off <= (YEAR_W+1)'(YEAR_MAX - YEAR_MIN);
    endfunction

    assign leap       = (year[1:0] == 2'b00) && ((r100 != 9'd0) || (r400 == '0));
    assign dim        = days_in_month(month, leap);
    assign load_ready = !busy;

    assign load_ok   = (load_month >= MON_JAN) && (load_month <= MON_DEC) &&
                       (load_day != 5'd0) && (load_dow <= DOW_SAT) &&
                       year_in_range(load_year);
    assign accept    = load_valid && !busy;
    assign take_load = accept && load_ok;
    // A load in the same cycle defers any tick until recalculation is over.
    assign adv       = !busy && !take_load && (day_tick || tick_pend);
    assign last_day  = !(day < dim);
    assign year_roll = adv && last_day && (month == MON_DEC);
    assign wrap      = year_roll && (year == YMAX);
    assign clamp_now = calc_done && (day > dim);

    assign res_start = take_load || wrap;
    assign res_inc   = year_roll && !wrap;
    assign res_val   = take_load ? RES_W'(load_year) : RES_W'(YMIN);

    cal_residue_calc #(
        .RES_W    (RES_W),
        .RST_R400 (RST_R400),
        .RST_R100 (RST_R100)
    ) u_residue (
        .clk       (clk),
        .reset     (reset),
        .start     (res_start),
        .start_val (res_val),
        .inc       (res_inc),
        .r400      (r400),
        .r100      (r100),
        .busy      (busy),
        .done      (calc_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            day         <= 5'd1;
            month       <= MON_JAN;
            year        <= YEAR_W'(RST_YEAR);
            dow         <= 3'(RST_DOW);
            tick_pend   <= 1'b0;
            month_end   <= 1'b0;
            year_end    <= 1'b0;
            year_wrap   <= 1'b0;
            load_err    <= 1'b0;
            day_clamped <= 1'b0;
            tick_lost   <= 1'b0;
        end else begin
            month_end   <= 1'b0;
            year_end    <= 1'b0;
            year_wrap   <= 1'b0;
            load_err    <= 1'b0;
            day_clamped <= 1'b0;

            if (accept && !load_ok) begin
                load_err <= 1'b1;
            end

            if (take_load) begin
                day   <= load_day;
                month <= load_month;
                year  <= load_year;
                dow   <= load_dow;
            end else if (adv) begin
                dow <= (dow == DOW_SAT) ? DOW_SUN : dow + 3'd1;
                if (!last_day) begin
                    day <= day + 5'd1;
                end else begin
                    day       <= 5'd1;
                    month_end <= 1'b1;
                    if (month == MON_DEC) begin
                        month    <= MON_JAN;
                        year_end <= 1'b1;
                        if (year == YMAX) begin
                            year      <= YMIN;
                            year_wrap <= 1'b1;
                        end else begin
                            year <= year + 1'b1;
                        end
                    end else begin
                        month <= month + 4'd1;
                    end
                end
            end else if (clamp_now) begin
                day         <= dim;
                day_clamped <= 1'b1;
            end

            // At most one tick can wait; anything beyond that is dropped.
            if (adv) begin
                tick_pend <= 1'b0;
                if (day_tick && tick_pend) begin
                    tick_lost <= 1'b1;
                end
            end else if (day_tick) begin
                if (tick_pend) begin
                    tick_lost <= 1'b1;
                end else begin
                    tick_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_date_unit.sv
// Directed bench for calendar_date_unit: leap handling, rollovers, loads,
// clamping, pending/lost ticks and asynchronous reset during recalculation.
module tb_calendar_date_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        day_tick;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_day;
    logic [3:0]  load_month;
    logic [11:0] load_year;
    logic [2:0]  load_dow;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [2:0]  dow;
    logic        leap;
    logic [4:0]  dim;
    logic        busy;
    logic        month_end;
    logic        year_end;
    logic        year_wrap;
    logic        load_err;
    logic        day_clamped;
    logic        tick_lost;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    calendar_date_unit dut (
        .clk         (clk),
        .reset       (reset),
        .day_tick    (day_tick),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_day    (load_day),
        .load_month  (load_month),
        .load_year   (load_year),
        .load_dow    (load_dow),
        .day         (day),
        .month       (month),
        .year        (year),
        .dow         (dow),
        .leap        (leap),
        .dim         (dim),
        .busy        (busy),
        .month_end   (month_end),
        .year_end    (year_end),
        .year_wrap   (year_wrap),
        .load_err    (load_err),
        .day_clamped (day_clamped),
        .tick_lost   (tick_lost)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            step();
        end
    endtask

    task automatic do_load(input logic [4:0] d, input logic [3:0] m,
                           input logic [11:0] y, input logic [2:0] w, input logic tk);
        load_valid = 1'b1;
        load_day   = d;
        load_month = m;
        load_year  = y;
        load_dow   = w;
        day_tick   = tk;
        step();
        load_valid = 1'b0;
        day_tick   = 1'b0;
    endtask

    task automatic check_date(input string tag, input int d, input int m, input int y, input int w);
        check({tag, ".day"},   32'(day),   32'(d));
        check({tag, ".month"}, 32'(month), 32'(m));
        check({tag, ".year"},  32'(year),  32'(y));
        check({tag, ".dow"},   32'(dow),   32'(w));
    endtask

    initial begin
        reset      = 1'b0;
        day_tick   = 1'b0;
        load_valid = 1'b0;
        load_day   = 5'd0;
        load_month = 4'd0;
        load_year  = 12'd0;
        load_dow   = 3'd0;
        step();
        step();
        check_date("rst", 1, 1, 2000, 6);
        check("rst.busy", 32'(busy), 0);
        check("rst.ready", 32'(load_ready), 1);
        check("rst.lost", 32'(tick_lost), 0);
        reset = 1'b1;
        step();
        check("rst.leap", 32'(leap), 1);
        check("rst.dim", 32'(dim), 31);

        // 60 consecutive ticks from 1 Jan 2000 reach 1 Mar 2000 via 29 Feb
        for (int i = 1; i <= 60; i++) begin
            day_tick = 1'b1;
            step();
            day_tick = 1'b0;
            check($sformatf("tick%0d.month_end", i), 32'(month_end), 32'((i == 31) || (i == 60)));
            if (i == 59) check_date("feb29", 29, 2, 2000, 2);
        end
        check_date("mar1_2000", 1, 3, 2000, 3);
        check("mar1_2000.year_end", 32'(year_end), 0);

        // Non-leap century year
        do_load(5'd28, 4'd2, 12'd1900, 3'd3, 1'b0);
        check_date("ld1900", 28, 2, 1900, 3);
        check("ld1900.ready", 32'(load_ready), 0);
        wait_busy(n);
        check("ld1900.busy_cycles", 32'(n), 9);
        check("ld1900.leap", 32'(leap), 0);
        check("ld1900.dim", 32'(dim), 28);
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
        check_date("mar1_1900", 1, 3, 1900, 4);
        check("mar1_1900.month_end", 32'(month_end), 1);

        // Year wrap at YEAR_MAX
        do_load(5'd31, 4'd12, 12'd4095, 3'd0, 1'b0);
        wait_busy(n);
        check("ld4095.busy_cycles", 32'(n), 12);
        check("ld4095.leap", 32'(leap), 0);
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
        check_date("wrap", 1, 1, 0, 1);
        check("wrap.month_end", 32'(month_end), 1);
        check("wrap.year_end", 32'(year_end), 1);
        check("wrap.year_wrap", 32'(year_wrap), 1);
        check("wrap.busy", 32'(busy), 1);
        wait_busy(n);
        check("wrap.busy_cycles", 32'(n), 2);
        check("wrap.leap", 32'(leap), 1);
        check("wrap.year_wrap_off", 32'(year_wrap), 0);

        // Day beyond month length is clamped at the end of recalculation
        do_load(5'd31, 4'd4, 12'd2023, 3'd0, 1'b0);
        check("ld2023.day_raw", 32'(day), 31);
        wait_busy(n);
        check("ld2023.busy_cycles", 32'(n), 7);
        check("ld2023.clamped", 32'(day_clamped), 1);
        check("ld2023.day", 32'(day), 30);
        step();
        check("ld2023.clamped_off", 32'(day_clamped), 0);

        // Rejected loads leave the date alone
        do_load(5'd10, 4'd13, 12'd2023, 3'd1, 1'b0);
        check("bad_month.err", 32'(load_err), 1);
        check("bad_month.busy", 32'(busy), 0);
        check_date("bad_month", 30, 4, 2023, 0);
        do_load(5'd0, 4'd5, 12'd2023, 3'd1, 1'b0);
        check("bad_day.err", 32'(load_err), 1);
        do_load(5'd5, 4'd5, 12'd2023, 3'd7, 1'b0);
        check("bad_dow.err", 32'(load_err), 1);
        check_date("bad_dow", 30, 4, 2023, 0);
        step();
        check("err_off", 32'(load_err), 0);

        // Load with simultaneous tick, plus a second tick while busy
        do_load(5'd31, 4'd1, 12'd2024, 3'd3, 1'b1);
        check_date("ld2024", 31, 1, 2024, 3);
        check("ld2024.busy", 32'(busy), 1);
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
        check("ld2024.lost", 32'(tick_lost), 1);
        wait_busy(n);
        check("ld2024.busy_cycles", 32'(n), 6);
        check_date("ld2024.pending_not_yet", 31, 1, 2024, 3);
        step();
        check_date("feb1_2024", 1, 2, 2024, 4);
        check("feb1_2024.month_end", 32'(month_end), 1);
        check("feb1_2024.leap", 32'(leap), 1);
        step();
        check_date("feb1_2024.no_extra", 1, 2, 2024, 4);
        check("lost.sticky", 32'(tick_lost), 1);

        // Asynchronous reset during CALC400 discards state and pending tick
        do_load(5'd15, 4'd6, 12'd2025, 3'd0, 1'b0);
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
        check("ld2025.busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_date("midreset", 1, 1, 2000, 6);
        check("midreset.busy", 32'(busy), 0);
        check("midreset.lost", 32'(tick_lost), 0);
        step();
        reset = 1'b1;
        step();
        step();
        step();
        check_date("after_reset", 1, 1, 2000, 6);
        check("after_reset.ready", 32'(load_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
